// File: rtl/riscv_hart_sequencer_pkg.sv
// Shared types and constants for the multi-hart fetch/issue/retire sequencer.
package riscv_hart_sequencer_pkg;

  localparam int MAX_HARTS   = 16;
  localparam int IALIGN_BITS = 2;

  typedef logic [$clog2(MAX_HARTS)-1:0] hart_id_t;
  typedef logic [31:0]                  riscv_inst32_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    RETIRE = 2'd3
  } seq_state_e;

  // Hart id width; a single hart still gets a 1-bit id.
  function automatic int hart_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_hart_sequencer_if.sv
// Instruction-memory, issue and retire handshakes between the sequencer and its neighbours.
interface riscv_hart_sequencer_if #(
  parameter int AW = 32,
  parameter int HW = 2
);
  import riscv_hart_sequencer_pkg::*;

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  riscv_inst32_t imem_rdata;

  logic          inst_valid;
  logic          inst_ready;
  riscv_inst32_t inst;
  logic [HW-1:0] inst_hart;
  logic [AW-1:0] inst_pc;

  logic          retire_valid;
  logic [HW-1:0] retire_hart;
  logic [AW-1:0] retire_next_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_hart, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, retire_valid, retire_hart, retire_next_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_hart, inst_pc,
    output imem_ack, imem_rdata, inst_ready, retire_valid, retire_hart, retire_next_pc
  );

endinterface

// File: rtl/riscv_hart_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping to 0.
module riscv_hart_sequencer_rr_arbiter #(
  parameter int N  = 4,
  parameter int HW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [HW-1:0] ptr,
  output logic [HW-1:0] grant_id,
  output logic          any_grant
);

  int unsigned sum_s;
  int unsigned idx_s;
  logic        hit_s;

  // scan N positions starting at ptr; the first hit wins
  always_comb begin
    grant_id  = {HW{1'b0}};
    any_grant = 1'b0;
    sum_s     = 32'd0;
    idx_s     = 32'd0;
    hit_s     = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s     = 32'(ptr) + 32'(i);
      idx_s     = (sum_s >= 32'(N)) ? (sum_s - 32'(N)) : sum_s;
      hit_s     = req[idx_s[HW-1:0]] & ~any_grant;
      grant_id  = hit_s ? idx_s[HW-1:0] : grant_id;
      any_grant = any_grant | hit_s;
    end
  end

endmodule

// File: rtl/riscv_hart_sequencer.sv
// Multi-hart barrel sequencer: per-hart PCs, round-robin hart pick, and a
// handshaked IDLE -> FETCH -> ISSUE -> RETIRE loop with registered outputs.
module riscv_hart_sequencer
  import riscv_hart_sequencer_pkg::*;
#(
  parameter int            NUM_HARTS = 4,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_PC  = {AW{1'b0}},
  parameter int            CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_HARTS-1:0]    hart_en,
  riscv_hart_sequencer_if.master  bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        retired_cnt,
  output logic                    seq_err
);

  localparam int HW = hart_width(NUM_HARTS);

  seq_state_e    state_r, state_s;
  logic [HW-1:0] cur_hart_r, cur_hart_s;
  logic [HW-1:0] ptr_r, ptr_s, ptr_after_s;
  logic [HW-1:0] grant_s;
  logic          any_grant_s;
  logic [AW-1:0] pc_r [NUM_HARTS];
  logic [AW-1:0] pc_s [NUM_HARTS];
  logic          imem_req_r, imem_req_s;
  logic [AW-1:0] imem_addr_r, imem_addr_s;
  logic          inst_valid_r, inst_valid_s;
  riscv_inst32_t inst_r, inst_s;
  logic [HW-1:0] inst_hart_r, inst_hart_s;
  logic [AW-1:0] inst_pc_r, inst_pc_s;
  logic          busy_r, busy_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic          err_r, err_s;

  riscv_hart_sequencer_rr_arbiter #(.N(NUM_HARTS), .HW(HW)) u_rr_arbiter (
    .req       (hart_en),
    .ptr       (ptr_r),
    .grant_id  (grant_s),
    .any_grant (any_grant_s)
  );

  assign ptr_after_s = (cur_hart_r == HW'(NUM_HARTS - 1)) ? {HW{1'b0}} : (cur_hart_r + HW'(1'b1));

  // next-state, PC update and next output values
  always_comb begin
    state_s      = state_r;
    cur_hart_s   = cur_hart_r;
    ptr_s        = ptr_r;
    pc_s         = pc_r;
    imem_req_s   = imem_req_r;
    imem_addr_s  = imem_addr_r;
    inst_valid_s = inst_valid_r;
    inst_s       = inst_r;
    inst_hart_s  = inst_hart_r;
    inst_pc_s    = inst_pc_r;
    cnt_s        = cnt_r;
    err_s        = err_r;
    case (state_r)
      IDLE: begin
        if (any_grant_s) begin
          cur_hart_s  = grant_s;
          imem_addr_s = pc_r[grant_s];
          imem_req_s  = 1'b1;
          state_s     = FETCH;
        end else begin
          imem_req_s  = 1'b0;
        end
      end
      FETCH: begin
        if (bus.imem_ack) begin
          inst_s       = bus.imem_rdata;
          inst_hart_s  = cur_hart_r;
          inst_pc_s    = imem_addr_r;
          imem_req_s   = 1'b0;
          inst_valid_s = 1'b1;
          state_s      = ISSUE;
        end else begin
          imem_req_s   = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.inst_ready) begin
          inst_valid_s = 1'b0;
          state_s      = RETIRE;
        end else begin
          inst_valid_s = 1'b1;
        end
      end
      RETIRE: begin
        if (bus.retire_valid) begin
          if (bus.retire_hart == cur_hart_r) begin
            pc_s[cur_hart_r] = {bus.retire_next_pc[AW-1:IALIGN_BITS], {IALIGN_BITS{1'b0}}};
            cnt_s   = cnt_r + CNT_W'(1'b1);
            ptr_s   = ptr_after_s;
            err_s   = err_r | (bus.retire_next_pc[IALIGN_BITS-1:0] != {IALIGN_BITS{1'b0}});
            state_s = IDLE;
          end else begin
            // a retire for the wrong hart is flagged and we keep waiting for ours
            err_s   = 1'b1;
          end
        end else begin
          state_s = RETIRE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    err_s  = err_s | (bus.retire_valid & (state_r != RETIRE));
    busy_s = (state_s != IDLE);
  end

  // state, PC file and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cur_hart_r   <= {HW{1'b0}};
      ptr_r        <= {HW{1'b0}};
      for (int i = 0; i < NUM_HARTS; i++) begin
        pc_r[i]    <= RESET_PC;
      end
      imem_req_r   <= 1'b0;
      imem_addr_r  <= {AW{1'b0}};
      inst_valid_r <= 1'b0;
      inst_r       <= 32'h0000_0000;
      inst_hart_r  <= {HW{1'b0}};
      inst_pc_r    <= {AW{1'b0}};
      busy_r       <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      cur_hart_r   <= cur_hart_s;
      ptr_r        <= ptr_s;
      pc_r         <= pc_s;
      imem_req_r   <= imem_req_s;
      imem_addr_r  <= imem_addr_s;
      inst_valid_r <= inst_valid_s;
      inst_r       <= inst_s;
      inst_hart_r  <= inst_hart_s;
      inst_pc_r    <= inst_pc_s;
      busy_r       <= busy_s;
      cnt_r        <= cnt_s;
      err_r        <= err_s;
    end
  end

  assign bus.imem_req   = imem_req_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst       = inst_r;
  assign bus.inst_hart  = inst_hart_r;
  assign bus.inst_pc    = inst_pc_r;
  assign busy           = busy_r;
  assign retired_cnt    = cnt_r;
  assign seq_err        = err_r;

endmodule

// File: tb/tb_riscv_hart_sequencer.sv
// Randomized bench for riscv_hart_sequencer against a transaction-level model of the hart loop.
module tb_riscv_hart_sequencer;
  import riscv_hart_sequencer_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int HW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  hart_en;
  logic          busy;
  logic [31:0]   retired_cnt;
  logic          seq_err;

  riscv_hart_sequencer_if #(.AW(AW), .HW(HW)) bus ();

  riscv_hart_sequencer #(.NUM_HARTS(N), .AW(AW), .RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hart_en(hart_en), .bus(bus),
    .busy(busy), .retired_cnt(retired_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  // inputs as consumed by the most recent rising edge
  logic c_rst, c_ack, c_ready, c_rv;
  logic [31:0] c_rdata, c_rnpc;
  logic [HW-1:0] c_rh;
  logic [N-1:0] c_en;

  always @(posedge clk) begin
    c_rst   <= rst;
    c_ack   <= bus.imem_ack;
    c_rdata <= bus.imem_rdata;
    c_ready <= bus.inst_ready;
    c_rv    <= bus.retire_valid;
    c_rh    <= bus.retire_hart;
    c_rnpc  <= bus.retire_next_pc;
    c_en    <= hart_en;
    cycle   <= cycle + 1;
  end

  // model: phase 0 waiting for a hart, 1 fetching, 2 issuing, 3 awaiting retire
  int phase = 0;
  int m_hart = 0;
  logic [31:0] m_addr, m_inst;
  logic [31:0] mpc [N];
  int mptr = 0;
  logic [31:0] mcnt;
  logic merr;
  bit mon_on = 1'b0;

  int iss_hart[$];
  int iss_cyc[$];
  int f_hart[$];
  logic [31:0] f_addr[$];

  int ack_max = 0, rdy_max = 0, ret_max = 0;
  int p_wrong = 0, p_mis = 0, p_jump = 0, p_spur = 0;
  bit en_rand = 1'b0, force_h1 = 1'b0, wrong_once = 1'b0, wrong_drv = 1'b0;
  int ack_wait = -1, rdy_wait = -1, ret_wait = -1;

  function automatic int pick(input logic [N-1:0] en, input int from);
    for (int i = 0; i < N; i++) begin
      int h;
      h = (from + i) % N;
      if (en[h]) return h;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  initial begin : monitor
    int nxt;
    int h;
    logic [31:0] np;
    forever begin
      @(negedge clk);
      if (c_rst === 1'b1) mon_on = 1'b1;
      if (mon_on) begin
        if (c_rst) begin
          phase = 0; mptr = 0; mcnt = 32'd0; merr = 1'b0; m_hart = 0; m_addr = 32'd0;
          for (int i = 0; i < N; i++) mpc[i] = 32'h0000_0000;
        end else begin
          nxt = phase;
          if (c_rv && phase != 3) merr = 1'b1;
          case (phase)
            0: begin
              h = pick(c_en, mptr);
              if (h >= 0) begin
                m_hart = h; m_addr = mpc[h]; nxt = 1;
                f_hart.push_back(h); f_addr.push_back(bus.imem_addr);
              end
            end
            1: if (c_ack) begin
              m_inst = c_rdata; nxt = 2;
              iss_hart.push_back(int'(bus.inst_hart)); iss_cyc.push_back(cycle);
            end
            2: if (c_ready) nxt = 3;
            3: if (c_rv) begin
              if (int'(c_rh) == m_hart) begin
                mpc[m_hart] = {c_rnpc[31:2], 2'b00};
                if (c_rnpc[1:0] != 2'b00) merr = 1'b1;
                mcnt = mcnt + 32'd1;
                mptr = (m_hart + 1) % N;
                nxt = 0;
              end else begin
                merr = 1'b1;
              end
            end
            default: nxt = 0;
          endcase
          phase = nxt;
        end
        chk("imem_req", 32'(bus.imem_req), 32'(phase == 1));
        chk("inst_valid", 32'(bus.inst_valid), 32'(phase == 2));
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("retired_cnt", retired_cnt, mcnt);
        chk("seq_err", 32'(seq_err), 32'(merr));
        if (phase == 1) chk("imem_addr", bus.imem_addr, m_addr);
        if (phase == 2) begin
          chk("inst", bus.inst, m_inst);
          chk("inst_hart", 32'(bus.inst_hart), 32'(m_hart));
          chk("inst_pc", bus.inst_pc, m_addr);
        end
        if (c_rst) begin
          chk("rst_imem_addr", bus.imem_addr, 32'h0);
          chk("rst_inst", bus.inst, 32'h0);
          chk("rst_inst_hart", 32'(bus.inst_hart), 32'h0);
          chk("rst_inst_pc", bus.inst_pc, 32'h0);
        end
      end
      // drive the memory, consumer and retire sides for the next edge
      bus.imem_ack = 1'b0; bus.inst_ready = 1'b0; bus.retire_valid = 1'b0;
      bus.imem_rdata = $urandom; bus.retire_hart = HW'($urandom_range(N - 1, 0));
      bus.retire_next_pc = $urandom;
      if (phase == 1) begin
        if (ack_wait < 0) ack_wait = $urandom_range(ack_max, 0);
        if (ack_wait == 0) begin bus.imem_ack = 1'b1; ack_wait = -1; end
        else ack_wait--;
      end
      if (phase == 2) begin
        if (rdy_wait < 0) rdy_wait = $urandom_range(rdy_max, 0);
        if (rdy_wait == 0) begin bus.inst_ready = 1'b1; rdy_wait = -1; end
        else rdy_wait--;
      end
      if (phase == 3) begin
        if (ret_wait < 0) ret_wait = $urandom_range(ret_max, 0);
        if (ret_wait == 0) begin
          ret_wait = -1;
          bus.retire_valid = 1'b1;
          bus.retire_hart = HW'(m_hart);
          np = m_addr + 32'd4;
          if ($urandom_range(99, 0) < p_jump) np = $urandom & 32'hFFFF_FFFC;
          if ($urandom_range(99, 0) < p_mis) np[1:0] = 2'($urandom_range(3, 1));
          if (force_h1 && m_hart == 1) begin np = 32'h0000_0103; force_h1 = 1'b0; end
          if (wrong_once && m_hart == 1) begin
            bus.retire_hart = HW'((m_hart + 1) % N);
            wrong_once = 1'b0; wrong_drv = 1'b1;
          end else if ($urandom_range(99, 0) < p_wrong) begin
            bus.retire_hart = HW'((m_hart + $urandom_range(N - 1, 1)) % N);
          end
          bus.retire_next_pc = np;
        end else begin
          ret_wait--;
        end
      end else if ($urandom_range(99, 0) < p_spur) begin
        bus.retire_valid = 1'b1;
      end
      if (en_rand && $urandom_range(99, 0) < 5) hart_en = N'($urandom);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad;
    int n0;
    int k;
    logic [31:0] cnt0;
    rst = 1'b1; hart_en = 4'b1111;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;
    bus.retire_valid = 1'b0; bus.retire_hart = 2'd0; bus.retire_next_pc = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_cnt", retired_cnt, 32'h0);
    chk("reset_err", 32'(seq_err), 32'h0);
    chk("reset_req", 32'(bus.imem_req), 32'h0);

    // all harts, zero-wait: 0,1,2,3,0 at one instruction per 4 cycles
    iss_hart.delete(); iss_cyc.delete(); f_hart.delete(); f_addr.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("a_cnt5", retired_cnt, 32'd5);
    chk("a_idle", 32'(busy), 32'h0);
    if (iss_hart.size() >= 5 && f_addr.size() >= 5) begin
      chk("a_hart0", 32'(iss_hart[0]), 32'd0);
      chk("a_hart1", 32'(iss_hart[1]), 32'd1);
      chk("a_hart2", 32'(iss_hart[2]), 32'd2);
      chk("a_hart3", 32'(iss_hart[3]), 32'd3);
      chk("a_hart0b", 32'(iss_hart[4]), 32'd0);
      chk("a_addr_h0_second", f_addr[4], 32'h0000_0004);
      for (int i = 0; i < 4; i++) chk("a_period", 32'(iss_cyc[i + 1] - iss_cyc[i]), 32'd4);
    end else begin
      chk("a_issue_count", 32'(iss_hart.size()), 32'd5);
    end

    // only harts 0 and 2 enabled
    hart_en = 4'b0101; ack_max = 1; rdy_max = 1; ret_max = 1;
    n0 = iss_hart.size();
    repeat (60) @(negedge clk);
    #1;
    bad = 0;
    for (int i = n0; i < iss_hart.size(); i++) if (iss_hart[i] != 0 && iss_hart[i] != 2) bad++;
    chk("b_only_0_2", 32'(bad), 32'd0);
    chk("b_some_issued", 32'(iss_hart.size() - n0 >= 4), 32'd1);
    hart_en = 4'b0000;
    repeat (30) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (busy !== 1'b0 || bus.imem_req !== 1'b0) bad++;
    end
    chk("b_none_enabled_idle", 32'(bad), 32'd0);

    // misaligned retire for hart 1
    rst = 1'b1; hart_en = 4'b1111; ack_max = 0; rdy_max = 0; ret_max = 0;
    repeat (2) @(negedge clk);
    #1;
    f_hart.delete(); f_addr.delete();
    force_h1 = 1'b1; rst = 1'b0;
    repeat (36) @(negedge clk);
    #1;
    chk("d_seq_err", 32'(seq_err), 32'd1);
    k = 0;
    for (int i = 0; i < f_hart.size(); i++) begin
      if (f_hart[i] == 1) begin
        if (k == 0) chk("d_h1_first_addr", f_addr[i], 32'h0000_0000);
        if (k == 1) chk("d_h1_aligned_addr", f_addr[i], 32'h0000_0100);
        k++;
      end
    end
    chk("d_h1_fetched_twice", 32'(k >= 2), 32'd1);

    // retire names the wrong hart while hart 1 is in flight
    wrong_drv = 1'b0; wrong_once = 1'b1;
    for (int i = 0; i < 40 && !wrong_drv; i++) begin @(negedge clk); #1; end
    if (wrong_drv) begin
      cnt0 = mcnt;
      @(negedge clk); #1;
      chk("e_still_busy", 32'(busy), 32'd1);
      chk("e_no_req", 32'(bus.imem_req), 32'd0);
      chk("e_no_valid", 32'(bus.inst_valid), 32'd0);
      chk("e_cnt_held", retired_cnt, cnt0);
      chk("e_err", 32'(seq_err), 32'd1);
      @(negedge clk); #1;
      chk("e_cnt_after", retired_cnt, cnt0 + 32'd1);
      chk("e_idle_after", 32'(busy), 32'd0);
    end else begin
      chk("e_wrong_seen", 32'd0, 32'd1);
    end

    // randomized traffic
    ack_max = 3; rdy_max = 2; ret_max = 2; en_rand = 1'b1;
    p_wrong = 10; p_mis = 5; p_jump = 20; p_spur = 3;
    repeat (1500) @(negedge clk);
    #1;

    // reset while a fetch is being acknowledged
    en_rand = 1'b0; p_wrong = 0; p_mis = 0; p_jump = 0; p_spur = 0; hart_en = 4'b1111;
    for (int i = 0; i < 200 && bus.imem_req !== 1'b1; i++) begin @(negedge clk); #1; end
    chk("f_req_seen", 32'(bus.imem_req), 32'd1);
    rst = 1'b1; bus.imem_ack = 1'b1;
    @(negedge clk); #1;
    chk("f_req0", 32'(bus.imem_req), 32'd0);
    chk("f_valid0", 32'(bus.inst_valid), 32'd0);
    chk("f_busy0", 32'(busy), 32'd0);
    chk("f_cnt0", retired_cnt, 32'd0);
    chk("f_err0", 32'(seq_err), 32'd0);
    f_hart.delete(); f_addr.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    if (f_hart.size() > 0) begin
      chk("f_first_hart", 32'(f_hart[0]), 32'd0);
      chk("f_first_addr", f_addr[0], 32'h0000_0000);
    end else begin
      chk("f_fetch_after_reset", 32'd0, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_hart_sequencer.md
Name: riscv_hart_sequencer

Overview:
Multicycle, multi-hart front-end sequencer for the next-generation core. It replaces the single-hart, single-cycle PC flow with NUM_HARTS per-hart program counters and a round-robin barrel scheduler. Each instruction passes through a handshaked fetch → issue → retire loop, with variable-latency instruction memory. It sits between instruction_memory (req/ack wrapper) and the controlpath/datapath pair, which consume inst/inst_hart/inst_pc and report retirement.

Parameters:
NUM_HARTS, 4, number of hardware threads (1..16)
AW, 32, address/PC width
RESET_PC, 32'h0000_0000, PC loaded into every hart on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
hart_en  in  NUM_HARTS  per-hart run enable; bit i=1 makes hart i eligible
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  AW  fetch address = PC of selected hart
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
inst_valid  out  1  issued instruction valid, held until inst_ready
inst_ready  in  1  controlpath/datapath accepts instruction
inst  out  32  issued instruction (riscv_inst32_t)
inst_hart  out  HW  hart id of issued instruction, HW=$clog2(NUM_HARTS) (min 1)
inst_pc  out  AW  PC of issued instruction
retire_valid  in  1  datapath finished current instruction
retire_hart  in  HW  hart id being retired
retire_next_pc  in  AW  next PC for that hart (pc+4 or branch/jump target)
busy  out  1  FSM not in IDLE
retired_cnt  out  CNT_W  total instructions retired, wraps modulo 2^CNT_W
seq_err  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at a clk edge): all hart PCs = RESET_PC. Round-robin pointer = 0. State = IDLE. All outputs 0: imem_req, imem_addr, inst_valid, inst, inst_hart, inst_pc, busy, retired_cnt, seq_err. Reset overrides any in-flight operation; a pending imem_ack or retire_valid in the reset cycle is ignored.
- States: IDLE → FETCH → ISSUE → RETIRE → IDLE. All outputs are registered.
- IDLE:
  - Select the first hart with hart_en set, searching from the pointer and wrapping at NUM_HARTS-1 → 0.
  - If none is enabled, stay in IDLE.
  - Otherwise latch the selected hart as cur_hart, drive imem_addr = pc[cur_hart], assert imem_req next cycle, and go to FETCH.
- FETCH:
  - imem_req is held high and imem_addr is held stable until imem_ack.
  - On ack: latch imem_rdata into inst and set inst_hart/inst_pc. Drop imem_req and raise inst_valid in the next cycle. Go to ISSUE.
  - An ack arriving in the same cycle the request is first asserted is legal (zero-wait memory).
- ISSUE:
  - inst_valid and its payload are held stable until inst_ready. On the transfer cycle go to RETIRE; inst_valid is low in the following cycle.
- RETIRE:
  - Wait for retire_valid.
  - If retire_hart == cur_hart: pc[cur_hart] = {retire_next_pc[AW-1:2], 2'b00}. retired_cnt increments by 1. Pointer = cur_hart+1, modulo NUM_HARTS. Go to IDLE.
  - If retire_next_pc[1:0] != 0, also set seq_err.
  - If retire_hart != cur_hart: set seq_err, leave PC, counter and pointer unchanged, and stay in RETIRE.
  - retire_valid seen in any state other than RETIRE: set seq_err and ignore it.
- Minimum loop with zero-wait memory and same-cycle ready/retire is 4 cycles per instruction (IDLE, FETCH, ISSUE, RETIRE).
- Clearing hart_en for the in-flight hart does not abort the instruction. It completes normally; the hart is skipped from the next selection onward.
- seq_err is cleared only by rst.
- With NUM_HARTS=1 the block degenerates to a single-hart multicycle sequencer; inst_hart is always 0.

Decomposition:
- riscv_package gains:
  - seq_state_e (IDLE, FETCH, ISSUE, RETIRE)
  - typedef hart_id_t sized from a package constant MAX_HARTS=16
  - constant IALIGN_BITS=2
- One sub-module, rr_arbiter: a combinational round-robin pick of the first set bit at or after the pointer. It takes NUM_HARTS-wide req and ptr inputs and returns grant_id plus any_grant.
- The PC array and FSM stay in riscv_hart_sequencer.

Test Plan:
- Reset with hart_en=4'b1111, RESET_PC=0, zero-wait imem, immediate ready/retire with next_pc=pc+4 → inst_hart sequence 0,1,2,3,0. Second visit to hart 0 fetches addr 0x4. retired_cnt=5 after 5 retires; one instruction per 4 cycles.
- hart_en=4'b0101 → only harts 0 and 2 alternate. hart_en=0 → busy stays 0 and imem_req never asserts.
- imem_ack delayed 3 cycles and inst_ready delayed 2 cycles → imem_req/imem_addr and inst_valid/inst are stable throughout. No duplicate issue.
- Hart 1 retires with retire_next_pc=0x103 → pc[1]=0x100 on the next fetch of hart 1, and seq_err=1.
- retire_hart=2 while cur_hart=1 → seq_err=1, FSM remains in RETIRE. A subsequent correct retire for hart 1 completes the loop.
- Assert rst during FETCH with imem_ack high in the same cycle → all outputs 0 next cycle, all PCs = RESET_PC. The first post-reset fetch is hart 0 at RESET_PC.
